sensor_sample_manager: RTL and testbench
========================================

// Module: sensor_sample_manager
// PURPOSE
// - Sits directly downstream of the SPI ADC controller. Issues its conversion requests
//   and alternates its channel select between temperature (ch7) and LDR (ch6).
// - Consumes each 12-bit result and box-car averages 2^AVG_LOG2 samples per channel.
// - Presents one averaged temperature/LDR pair per averaging window to the display/UART stage.
// PARAMETERS
// - SAMPLE_PERIOD_P   50000  Clk_i cycles between conversion requests (1 ms @ 50 MHz); >= 4
// - AVG_LOG2_P        3      log2 of samples averaged per channel (8); legal 0..6
// - DATA_W_P          12     ADC result width
// - TIMEOUT_CYCLES_P  4096   max Clk_i cycles from Start_o to Data_Valid_i (SAMPLE_TIMEOUT_EN only)
// PORTS
// - Clk_i          in   1         system clock
// - Reset_i        in   1         asynchronous, active-low reset
// - Enable_i       in   1         1 = run sampling schedule; 0 = finish current conversion, then halt
// - Start_o        out  1         one-cycle conversion request to controller Switch_i
// - Channel_o      out  1         to controller Temp_LDR_i; 1 = temperature (ch7), 0 = LDR (ch6)
// - Data_i         in   DATA_W_P  ADC result from controller
// - Data_Valid_i   in   1         one-cycle strobe; Data_i is valid in the same cycle
// - Temp_Avg_o     out  DATA_W_P  averaged temperature code
// - Ldr_Avg_o      out  DATA_W_P  averaged LDR code
// - Avg_Valid_o    out  1         one-cycle strobe; both averages updated in the same cycle
// - Timeout_o      out  1         sticky error flag (SAMPLE_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
// - Reset values: Start_o=0, Channel_o=1, Temp_Avg_o=0, Ldr_Avg_o=0, Avg_Valid_o=0, Timeout_o=0.
//   Reset also clears FSM to IDLE, period counter, sample counter and both accumulators.
// - FSM states:
//   - IDLE: leave when Enable_i=1 -> WAIT_TICK; period counter cleared.
//   - WAIT_TICK: count to SAMPLE_PERIOD_P-1; -> START. If Enable_i=0 -> IDLE.
//   - START: Start_o=1 for exactly one cycle -> WAIT_DATA.
//   - WAIT_DATA: on Data_Valid_i -> ACCUM. Start_o held 0; Enable_i ignored.
//   - ACCUM: add the latched Data_i into the accumulator selected by Channel_o.
//     - Channel_o=0 (LDR) increments the sample counter.
//     - Toggle Channel_o. Counter wrapped to 0 -> OUTPUT, else -> WAIT_TICK.
//   - OUTPUT: Temp_Avg_o = acc_t >> AVG_LOG2_P, Ldr_Avg_o = acc_l >> AVG_LOG2_P (truncate).
//     Avg_Valid_o=1 for one cycle; clear both accumulators -> WAIT_TICK (IDLE if Enable_i=0).
// - Channel_o changes only in ACCUM, so it is stable >= SAMPLE_PERIOD_P cycles before Start_o.
//   This covers the controller's registered channel select.
// - Sequence per window: T,L,T,L,... starting with temperature; exactly 2^AVG_LOG2_P samples each.
// - Accumulators are DATA_W_P+AVG_LOG2_P bits and cannot overflow.
//   Sample counter is AVG_LOG2_P bits, wraps 2^N-1 -> 0.
// - Data_Valid_i outside WAIT_DATA is ignored; no accumulation, no state change.
// - Data_Valid_i coincident with Start_o is ignored (belongs to no request).
// - Enable_i deassert mid-window: partial accumulators are kept. Re-enable resumes the window
//   with the same Channel_o. Only reset clears a partial window.
// - Async reset mid-conversion: block returns to IDLE immediately. A late Data_Valid_i is
//   ignored as above.
// - Latency: Data_Valid_i -> accumulator update 1 cycle.
//   Final LDR Data_Valid_i -> Avg_Valid_o 2 cycles.
// CONFIGURATION
// - SAMPLE_TIMEOUT_EN defined:
//   - WAIT_DATA counts cycles; reaching TIMEOUT_CYCLES_P with no Data_Valid_i sets Timeout_o
//     (sticky until reset).
//   - The FSM discards the whole window (clears accumulators, counter, Channel_o=1) -> WAIT_TICK.
// - SAMPLE_TIMEOUT_EN undefined: no timeout counter; WAIT_DATA waits forever; Timeout_o tied 0.
// TESTING
// - T1 Reset: assert Reset_i=0 mid-WAIT_DATA.
//   -> all outputs at reset values same cycle; FSM IDLE; no Start_o.
// - T2 Schedule: SAMPLE_PERIOD_P=10, Enable_i=1, model responds 30 cycles after Start_o.
//   -> Start_o pulses 1 cycle wide, Channel_o sequence 1,0,1,0.
// - T3 Average: AVG_LOG2_P=2, temp codes 100,101,102,103, LDR codes 4095 x4.
//   -> one Avg_Valid_o, Temp_Avg_o=101, Ldr_Avg_o=4095.
// - T4 Spurious: Data_Valid_i=1 with Data_i=12'hABC during WAIT_TICK.
//   -> averages unchanged from the T3-style expected values.
// - T5 Pause: Enable_i=0 after 3 samples, wait 500 cycles, re-enable.
//   -> no Start_o while paused; window completes with correct averages of all 8 samples.
// - T6 Timeout (SAMPLE_TIMEOUT_EN, TIMEOUT_CYCLES_P=64): model never answers.
//   -> Timeout_o=1 at cycle 64 after Start_o, next Start_o has Channel_o=1, no Avg_Valid_o.

Source files
------------

// File: rtl/sensor_sample_manager.sv
// Sensor sample manager: schedules ADC conversions, alternating temp/LDR,
// and box-car averages each channel. Optional timeout: SAMPLE_TIMEOUT_EN.
module sensor_sample_manager #(
  parameter int SAMPLE_PERIOD_P  = 50000,
  parameter int AVG_LOG2_P       = 3,
  parameter int DATA_W_P         = 12,
  parameter int TIMEOUT_CYCLES_P = 4096
) (
  input  logic                Clk_i,
  input  logic                Reset_i,
  input  logic                Enable_i,
  output logic                Start_o,
  output logic                Channel_o,
  input  logic [DATA_W_P-1:0] Data_i,
  input  logic                Data_Valid_i,
  output logic [DATA_W_P-1:0] Temp_Avg_o,
  output logic [DATA_W_P-1:0] Ldr_Avg_o,
  output logic                Avg_Valid_o,
  output logic                Timeout_o
);

  localparam int AW = DATA_W_P + AVG_LOG2_P;
  localparam int PW = $clog2(SAMPLE_PERIOD_P);
  localparam int CW = (AVG_LOG2_P > 0) ? AVG_LOG2_P : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((1 << AVG_LOG2_P) - 1);
  localparam logic [PW-1:0] TICK_LAST =
    PW'(SAMPLE_PERIOD_P - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    WAIT_DATA,
    ACCUM,
    OUTPUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]       per_cnt;
  logic [CW-1:0]       smp_cnt;
  logic [AW-1:0]       acc_t;
  logic [AW-1:0]       acc_l;
  logic [AW-1:0]       acc_l_sum;
  logic [DATA_W_P-1:0] data_q;
  logic                tick_done;
  logic                smp_wrap;
  logic                to_hit;

  assign tick_done = (per_cnt == TICK_LAST);
  assign smp_wrap  = !Channel_o && (smp_cnt == CNT_LAST);
  assign acc_l_sum = acc_l + AW'(data_q);

`ifdef SAMPLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES_P + 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES_P - 1);

  logic [TW-1:0] to_cnt;
  logic          timeout_q;

  // Counting starts on the request cycle itself.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      to_cnt <= '0;
    end else if (state == START ||
                 state == WAIT_DATA) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_hit = (state == WAIT_DATA) &&
                  !Data_Valid_i &&
                  (to_cnt == TO_LAST);

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      timeout_q <= 1'b0;
    end else if (to_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign Timeout_o = timeout_q;
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYCLES_P != 0);
  assign to_hit    = 1'b0;
  assign Timeout_o = 1'b0;
`endif

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (Enable_i) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!Enable_i)      state_nxt = IDLE;
        else if (tick_done) state_nxt = START;
      end
      START: begin
        state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (Data_Valid_i) state_nxt = ACCUM;
        else if (to_hit)  state_nxt = WAIT_TICK;
      end
      ACCUM: begin
        state_nxt = smp_wrap ? OUTPUT : WAIT_TICK;
      end
      OUTPUT: begin
        state_nxt = Enable_i ? WAIT_TICK : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    Start_o     = 1'b0;
    Avg_Valid_o = 1'b0;
    unique case (state)
      START:   Start_o     = 1'b1;
      OUTPUT:  Avg_Valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      per_cnt <= '0;
    end else if (state == WAIT_TICK && !tick_done) begin
      per_cnt <= per_cnt + PW'(1);
    end else begin
      per_cnt <= '0;
    end
  end

  // The last sample of a window is always LDR, so the averages are
  // captured from the running sums as that sample is folded in.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      data_q     <= '0;
      acc_t      <= '0;
      acc_l      <= '0;
      smp_cnt    <= '0;
      Channel_o  <= 1'b1;
      Temp_Avg_o <= '0;
      Ldr_Avg_o  <= '0;
    end else if (to_hit) begin
      acc_t     <= '0;
      acc_l     <= '0;
      smp_cnt   <= '0;
      Channel_o <= 1'b1;
    end else begin
      if (state == WAIT_DATA && Data_Valid_i) begin
        data_q <= Data_i;
      end
      if (state == ACCUM) begin
        if (Channel_o) begin
          acc_t <= acc_t + AW'(data_q);
        end else begin
          acc_l   <= acc_l_sum;
          smp_cnt <= smp_wrap ? '0 : smp_cnt + CW'(1);
        end
        Channel_o <= !Channel_o;
        if (smp_wrap) begin
          Temp_Avg_o <= DATA_W_P'(acc_t >> AVG_LOG2_P);
          Ldr_Avg_o  <= DATA_W_P'(acc_l_sum >> AVG_LOG2_P);
        end
      end
      if (state == OUTPUT) begin
        acc_t <= '0;
        acc_l <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sensor_sample_manager.sv
// Bench for sensor_sample_manager: table-driven windows with a
// scoreboard of expected averages and hand-written corner sequences.
module tb_sensor_sample_manager;

  localparam int PER  = 10;
  localparam int NLOG = 2;
  localparam int DW   = 12;
  localparam int TO   = 64;
  localparam int RESP = 30;
  localparam int NV   = 5;

  logic          clk;
  logic          Reset_i;
  logic          Enable_i;
  logic          Start_o;
  logic          Channel_o;
  logic [DW-1:0] Data_i;
  logic          Data_Valid_i;
  logic [DW-1:0] Temp_Avg_o;
  logic [DW-1:0] Ldr_Avg_o;
  logic          Avg_Valid_o;
  logic          Timeout_o;

  sensor_sample_manager #(
    .SAMPLE_PERIOD_P (PER),
    .AVG_LOG2_P      (NLOG),
    .DATA_W_P        (DW),
    .TIMEOUT_CYCLES_P(TO)
  ) dut (
    .Clk_i       (clk),
    .Reset_i     (Reset_i),
    .Enable_i    (Enable_i),
    .Start_o     (Start_o),
    .Channel_o   (Channel_o),
    .Data_i      (Data_i),
    .Data_Valid_i(Data_Valid_i),
    .Temp_Avg_o  (Temp_Avg_o),
    .Ldr_Avg_o   (Ldr_Avg_o),
    .Avg_Valid_o (Avg_Valid_o),
    .Timeout_o   (Timeout_o)
  );

  typedef struct {
    int t[4];
    int l[4];
    int et;
    int el;
  } vec_t;

  typedef struct {
    int t;
    int l;
    int c;
  } exp_t;

  vec_t tbl[NV];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void check(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endfunction

  function automatic void set_vec(
    int i, int t0, int t1, int t2, int t3,
    int l0, int l1, int l2, int l3, int et, int el);
    tbl[i].t[0] = t0; tbl[i].t[1] = t1;
    tbl[i].t[2] = t2; tbl[i].t[3] = t3;
    tbl[i].l[0] = l0; tbl[i].l[1] = l1;
    tbl[i].l[2] = l2; tbl[i].l[3] = l3;
    tbl[i].et = et;
    tbl[i].el = el;
  endfunction

  always @(negedge clk) begin
    if (Reset_i && Avg_Valid_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL avg_unexpected got t=%0d l=%0d want none",
                 Temp_Avg_o, Ldr_Avg_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("avg_temp", int'(Temp_Avg_o), e.t);
        check("avg_ldr", int'(Ldr_Avg_o), e.l);
        check("avg_cycle", cyc, e.c);
      end
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (Start_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL start_wait got none want Start_o");
    end
  endtask

  task automatic run_window(input int v, input int pause_after,
                            input int abort_at, output bit aborted);
    bit ok;
    int n;
    aborted = 1'b0;
    for (int s = 0; s < 8; s++) begin
      wait_start(ok);
      if (!ok) begin
        aborted = 1'b1;
        return;
      end
      check("channel", int'(Channel_o), int'(s % 2 == 0));
      Data_Valid_i = 1'b1;
      Data_i = 12'hABC;
      @(negedge clk);
      check("start_width", int'(Start_o), 0);
      Data_Valid_i = 1'b0;
      if (s == abort_at) begin
        aborted = 1'b1;
        return;
      end
      repeat (RESP - 1) @(negedge clk);
      Data_i = (s % 2 == 0) ? DW'(tbl[v].t[s/2])
                            : DW'(tbl[v].l[s/2]);
      Data_Valid_i = 1'b1;
      if (s == 7) begin
        exp_t e;
        e.t = tbl[v].et;
        e.l = tbl[v].el;
        e.c = cyc + 2;
        sbq.push_back(e);
      end
      @(negedge clk);
      Data_Valid_i = 1'b0;
      if (s == pause_after) begin
        Enable_i = 1'b0;
        n = 0;
        repeat (500) begin
          @(negedge clk);
          if (Start_o) n++;
        end
        check("pause_starts", n, 0);
        Enable_i = 1'b1;
      end else begin
        repeat (3) @(negedge clk);
        Data_i = 12'hABC;
        Data_Valid_i = 1'b1;
        @(negedge clk);
        Data_Valid_i = 1'b0;
      end
    end
  endtask

  initial begin
    bit ab;
    int n;
    set_vec(0, 100, 101, 102, 103,
            4095, 4095, 4095, 4095, 101, 4095);
    set_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(2, 4095, 4095, 4095, 4095,
            1, 2, 3, 5, 4095, 2);
    set_vec(3, 7, 0, 0, 0, 3, 0, 0, 0, 1, 0);
    set_vec(4, 2048, 2049, 2050, 2052,
            10, 20, 30, 40, 2049, 25);

    Reset_i = 1'b0;
    Enable_i = 1'b0;
    Data_Valid_i = 1'b0;
    Data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_start", int'(Start_o), 0);
    check("rst_channel", int'(Channel_o), 1);
    check("rst_temp", int'(Temp_Avg_o), 0);
    check("rst_ldr", int'(Ldr_Avg_o), 0);
    check("rst_avg_valid", int'(Avg_Valid_o), 0);
    check("rst_timeout", int'(Timeout_o), 0);
    Reset_i = 1'b1;

    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (Start_o) n++;
    end
    check("idle_starts", n, 0);
    Enable_i = 1'b1;

    for (int v = 0; v < NV; v++) begin
      run_window(v, -1, -1, ab);
    end

    run_window(0, 2, -1, ab);

    run_window(4, -1, 3, ab);
    repeat (4) @(negedge clk);
    Reset_i = 1'b0;
    #1;
    check("mid_rst_start", int'(Start_o), 0);
    check("mid_rst_channel", int'(Channel_o), 1);
    check("mid_rst_temp", int'(Temp_Avg_o), 0);
    check("mid_rst_ldr", int'(Ldr_Avg_o), 0);
    check("mid_rst_avg_valid", int'(Avg_Valid_o), 0);
    @(negedge clk);
    Enable_i = 1'b0;
    Reset_i = 1'b1;
    repeat (20) @(negedge clk);
    Data_i = 12'h7FF;
    Data_Valid_i = 1'b1;
    @(negedge clk);
    Data_Valid_i = 1'b0;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (Start_o) n++;
    end
    check("post_rst_starts", n, 0);
    Enable_i = 1'b1;
    run_window(2, -1, -1, ab);

`ifdef SAMPLE_TIMEOUT_EN
    run_window(3, -1, 1, ab);
    n = 1;
    while (!Timeout_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", n, TO);
    run_window(0, -1, -1, ab);
    check("timeout_sticky", int'(Timeout_o), 1);
`else
    check("timeout_tied", int'(Timeout_o), 0);
`endif

    repeat (20) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
